// File: rtl/dvp_cap_pkg.sv
// Shared types and width helpers for the DVP frame capture engine.
// Provides the capture FSM state enum and word/slot width derivations.
package dvp_cap_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_CAPTURE,
      S_DONE
   } state_e;

   function automatic int word_w(input int dw, input int bpp, input int ppw);
      return dw * bpp * ppw;
   endfunction

   // Index width for a counter over n items (at least one bit).
   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dvp_frame_capture_if.sv
// Camera/control inputs and frame-RAM/status outputs of the capture engine.
// slave: capture engine side; master: camera + RAM + controller side.
interface dvp_frame_capture_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 12,
   parameter int ADDR_W = 17,
   parameter int WORD_W = 32
);
   logic              ARM;
   logic              CONT;
   logic [CNT_W-1:0]  X_START;
   logic [CNT_W-1:0]  X_END;
   logic [CNT_W-1:0]  Y_START;
   logic [CNT_W-1:0]  Y_END;
   logic              VSYNC;
   logic              HREF;
   logic [DATA_W-1:0] CAM_DATA;
   logic              RAM_WE;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [WORD_W-1:0] RAM_WDATA;
   logic              FRAME_READY;
   logic              BUSY;
   logic              OVERFLOW;
   logic [7:0]        FRAME_CNT;
   logic [ADDR_W:0]   WORD_CNT;

   modport slave (
      input  ARM, CONT, X_START, X_END, Y_START, Y_END,
      input  VSYNC, HREF, CAM_DATA,
      output RAM_WE, RAM_ADDR, RAM_WDATA,
      output FRAME_READY, BUSY, OVERFLOW, FRAME_CNT, WORD_CNT
   );

   modport master (
      output ARM, CONT, X_START, X_END, Y_START, Y_END,
      output VSYNC, HREF, CAM_DATA,
      input  RAM_WE, RAM_ADDR, RAM_WDATA,
      input  FRAME_READY, BUSY, OVERFLOW, FRAME_CNT, WORD_CNT
   );
endinterface

// File: rtl/dvp_pixel_packer.sv
// Assembles camera beats into pixels and kept pixels into RAM words.
// Ports: clk_i/rst_i, clr_i (drop all partial state), beat_i/data_i
// (accepted beat), href_i, flush_i (line end), keep_i (pixel in window);
// pix_done_o (pixel completes now), word_vld_o/word_o (word to write now).
module dvp_pixel_packer
   import dvp_cap_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int PIX_PER_WORD  = 2
) (
   input  logic                                              clk_i,
   input  logic                                              rst_i,
   input  logic                                              clr_i,
   input  logic                                              beat_i,
   input  logic                                              href_i,
   input  logic                                              flush_i,
   input  logic                                              keep_i,
   input  logic [DATA_W-1:0]                                 data_i,
   output logic                                              pix_done_o,
   output logic                                              word_vld_o,
   output logic [word_w(DATA_W,BYTES_PER_PIX,PIX_PER_WORD)-1:0] word_o
);
   localparam int PIX_W  = DATA_W * BYTES_PER_PIX;
   localparam int WORD_W = word_w(DATA_W, BYTES_PER_PIX, PIX_PER_WORD);
   localparam int SLOT_W = slot_w(PIX_PER_WORD);
   localparam int PH_W   = slot_w(BYTES_PER_PIX);

   logic [PH_W-1:0]   phase_q, phase_d;
   logic [PIX_W-1:0]  pix_q, pix_d, pix_full;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [WORD_W-1:0] acc_q, acc_d, acc_push;
   logic              last_beat, push, word_full;

   always_comb begin
      // Earlier beats shift up so the first beat lands in the MSBs.
      pix_full   = (pix_q << DATA_W) | PIX_W'(data_i);
      acc_push   = (acc_q << PIX_W) | WORD_W'(pix_full);
      last_beat  = (phase_q == PH_W'(BYTES_PER_PIX - 1));
      pix_done_o = beat_i && last_beat;
      push       = pix_done_o && keep_i;
      word_full  = push && (slot_q == SLOT_W'(PIX_PER_WORD - 1));
      phase_d    = phase_q;
      pix_d      = pix_q;
      slot_d     = slot_q;
      acc_d      = acc_q;
      word_vld_o = 1'b0;
      word_o     = acc_push;
      if (clr_i) begin
         phase_d    = '0;
         pix_d      = '0;
         slot_d     = '0;
         acc_d      = '0;
         pix_done_o = 1'b0;
      end else begin
         if (!href_i) begin
            phase_d = '0;
         end else if (beat_i) begin
            pix_d   = pix_full;
            phase_d = last_beat ? '0 : phase_q + 1'b1;
         end
         if (push) begin
            acc_d      = acc_push;
            slot_d     = word_full ? '0 : slot_q + 1'b1;
            word_vld_o = word_full;
         end else if (flush_i && (slot_q != '0)) begin
            // Left-align the kept pixels; empty low slots shift in zero.
            word_o     = acc_q << ((PIX_PER_WORD - int'(slot_q)) * PIX_W);
            word_vld_o = 1'b1;
            slot_d     = '0;
            acc_d      = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= '0;
         pix_q   <= '0;
         slot_q  <= '0;
         acc_q   <= '0;
      end else begin
         phase_q <= phase_d;
         pix_q   <= pix_d;
         slot_q  <= slot_d;
         acc_q   <= acc_d;
      end
   end
endmodule

// File: rtl/dvp_frame_capture.sv
// DVP camera capture: VSYNC/HREF framing, crop window, frame RAM writes.
// Ports: PCLK (sole clock), HRESET (async, active high), bus (slave side:
// camera + control in, RAM write port + FRAME_READY/BUSY/OVERFLOW/counts out).
module dvp_frame_capture
   import dvp_cap_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int PIX_PER_WORD  = 2,
   parameter int ADDR_W        = 17,
   parameter int DEPTH         = 2**ADDR_W,
   parameter int CNT_W         = 12
) (
   input  logic                PCLK,
   input  logic                HRESET,
   dvp_frame_capture_if.slave  bus
);
   localparam int WORD_W = word_w(DATA_W, BYTES_PER_PIX, PIX_PER_WORD);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_e            state_q, state_d;
   logic              vsync_q, href_q, cont_q, cont_d;
   logic [CNT_W-1:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d, wc_out_q, wc_out_d;
   logic              we_q, we_d, rdy_q, rdy_d, busy_q, busy_d, ovf_q, ovf_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d, word;
   logic [7:0]        fcnt_q, fcnt_d;
   logic              v_fall, v_rise, h_fall, cap, no_cap, beat, flush;
   logic              start, finish, keep, pix_done, word_vld;

   always_comb begin
      v_fall = vsync_q && !bus.VSYNC;
      v_rise = !vsync_q && bus.VSYNC;
      h_fall = href_q && !bus.HREF;
      // Dropping ARM aborts at once: the beat in that cycle is not taken.
      cap    = (state_q == S_CAPTURE) && bus.ARM;
      no_cap = !cap;
      beat   = cap && bus.HREF && !bus.VSYNC;
      flush  = cap && h_fall;
      start  = (state_q == S_SYNC) && bus.ARM && v_fall;
      finish = cap && v_rise;
      keep   = (x_q >= xs_q) && (x_q <= xe_q) &&
               (y_q >= ys_q) && (y_q <= ye_q);
   end

   dvp_pixel_packer #(
      .DATA_W       (DATA_W),
      .BYTES_PER_PIX(BYTES_PER_PIX),
      .PIX_PER_WORD (PIX_PER_WORD)
   ) u_pack (
      .clk_i     (PCLK),
      .rst_i     (HRESET),
      .clr_i     (no_cap),
      .beat_i    (beat),
      .href_i    (bus.HREF),
      .flush_i   (flush),
      .keep_i    (keep),
      .data_i    (bus.CAM_DATA),
      .pix_done_o(pix_done),
      .word_vld_o(word_vld),
      .word_o    (word)
   );

   always_ff @(posedge PCLK or posedge HRESET) begin
      if (HRESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (bus.ARM) state_d = S_SYNC;
         S_SYNC:    if (!bus.ARM) state_d = S_IDLE;
                    else if (v_fall) state_d = S_CAPTURE;
         S_CAPTURE: if (!bus.ARM) state_d = S_IDLE;
                    else if (v_rise) state_d = S_DONE;
         S_DONE:    if (cont_q) state_d = S_SYNC;
                    else if (!bus.ARM) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cont_d   = cont_q;
      xs_d     = xs_q;
      xe_d     = xe_q;
      ys_d     = ys_q;
      ye_d     = ye_q;
      x_d      = x_q;
      y_d      = y_q;
      wcnt_d   = wcnt_q;
      wc_out_d = wc_out_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdy_d    = rdy_q;
      busy_d   = (state_d != S_IDLE);
      ovf_d    = ovf_q;
      fcnt_d   = fcnt_q;
      if ((state_q == S_IDLE) && bus.ARM) begin
         ovf_d  = 1'b0;
         fcnt_d = '0;
      end
      if (state_d == S_IDLE) rdy_d = 1'b0;
      if (start) begin
         cont_d = bus.CONT;
         xs_d   = bus.X_START;
         xe_d   = bus.X_END;
         ys_d   = bus.Y_START;
         ye_d   = bus.Y_END;
         x_d    = '0;
         y_d    = '0;
         wcnt_d = '0;
         rdy_d  = 1'b0;
      end else begin
         if (h_fall)        x_d = '0;
         else if (pix_done) x_d = x_q + 1'b1;
         if (flush)         y_d = y_q + 1'b1;
      end
      if (word_vld) begin
         if (wcnt_q < DEPTH_C) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = word;
            wcnt_d  = wcnt_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
      if (finish) begin
         rdy_d    = 1'b1;
         fcnt_d   = fcnt_q + 1'b1;
         wc_out_d = wcnt_d;
      end
   end

   always_ff @(posedge PCLK or posedge HRESET) begin
      if (HRESET) begin
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
         cont_q   <= 1'b0;
         xs_q     <= '0;
         xe_q     <= '0;
         ys_q     <= '0;
         ye_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         wcnt_q   <= '0;
         wc_out_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         vsync_q  <= bus.VSYNC;
         href_q   <= bus.HREF;
         cont_q   <= cont_d;
         xs_q     <= xs_d;
         xe_q     <= xe_d;
         ys_q     <= ys_d;
         ye_q     <= ye_d;
         x_q      <= x_d;
         y_q      <= y_d;
         wcnt_q   <= wcnt_d;
         wc_out_q <= wc_out_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign bus.RAM_WE      = we_q;
   assign bus.RAM_ADDR    = addr_q;
   assign bus.RAM_WDATA   = wdata_q;
   assign bus.FRAME_READY = rdy_q;
   assign bus.BUSY        = busy_q;
   assign bus.OVERFLOW    = ovf_q;
   assign bus.FRAME_CNT   = fcnt_q;
   assign bus.WORD_CNT    = wc_out_q;
endmodule

// File: tb/tb_dvp_frame_capture.sv
// Directed bench for dvp_frame_capture: default instance plus a DEPTH=4
// instance sharing the same camera stimulus.
module tb_dvp_frame_capture;
   import dvp_cap_pkg::*;

   logic        clk = 1'b0;
   logic        hreset = 1'b1;
   logic        arm = 0, cont = 0, vsync = 1, href = 0;
   logic [11:0] xs = 0, xe = 0, ys = 0, ye = 0;
   logic [7:0]  data = 0;

   always #5 clk = ~clk;

   dvp_frame_capture_if ifa ();
   dvp_frame_capture_if ifb ();

   assign ifa.ARM = arm;     assign ifb.ARM = arm;
   assign ifa.CONT = cont;   assign ifb.CONT = cont;
   assign ifa.X_START = xs;  assign ifb.X_START = xs;
   assign ifa.X_END = xe;    assign ifb.X_END = xe;
   assign ifa.Y_START = ys;  assign ifb.Y_START = ys;
   assign ifa.Y_END = ye;    assign ifb.Y_END = ye;
   assign ifa.VSYNC = vsync; assign ifb.VSYNC = vsync;
   assign ifa.HREF = href;   assign ifb.HREF = href;
   assign ifa.CAM_DATA = data;
   assign ifb.CAM_DATA = data;

   dvp_frame_capture u_a (.PCLK(clk), .HRESET(hreset), .bus(ifa));
   dvp_frame_capture #(.DEPTH(4)) u_b (.PCLK(clk), .HRESET(hreset), .bus(ifb));

   int total = 0;
   int bad = 0;
   logic [16:0] qa_addr[$];
   logic [31:0] qa_data[$];
   int nb = 0;
   logic busy_watch = 0;
   int busy_drop = 0;

   always @(negedge clk) begin
      if (ifa.RAM_WE === 1'b1) begin
         qa_addr.push_back(ifa.RAM_ADDR);
         qa_data.push_back(ifa.RAM_WDATA);
      end
      if (ifb.RAM_WE === 1'b1) nb++;
      if (busy_watch && ifa.BUSY !== 1'b1) busy_drop++;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_we"}, 64'(ifa.RAM_WE), 0);
      chk({t, "_addr"}, 64'(ifa.RAM_ADDR), 0);
      chk({t, "_wdata"}, 64'(ifa.RAM_WDATA), 0);
      chk({t, "_rdy"}, 64'(ifa.FRAME_READY), 0);
      chk({t, "_busy"}, 64'(ifa.BUSY), 0);
      chk({t, "_ovf"}, 64'(ifa.OVERFLOW), 0);
      chk({t, "_fcnt"}, 64'(ifa.FRAME_CNT), 0);
      chk({t, "_wcnt"}, 64'(ifa.WORD_CNT), 0);
      chk({t, "_b_ovf"}, 64'(ifb.OVERFLOW), 0);
   endtask

   task automatic frame(input int w, input int h);
      logic [7:0] b;
      b = 8'h01;
      vsync = 1; href = 0;
      repeat (4) cyc();
      vsync = 0;
      repeat (2) cyc();
      for (int l = 0; l < h; l++) begin
         href = 1;
         for (int k = 0; k < 2 * w; k++) begin
            data = b;
            b++;
            cyc();
         end
         href = 0; data = 0;
         repeat (3) cyc();
      end
      vsync = 1;
      repeat (4) cyc();
   endtask

   typedef struct {
      logic [11:0] xs, xe, ys, ye;
      int          w, h, nw;
      logic [31:0] d0, d1, dl;
      int          bnw;
      logic        bovf;
   } vec_t;

   vec_t vt[5];

   initial begin
      int n0, n1;
      vt[0] = '{0, 3, 0, 2, 4, 3, 6, 32'h01020304, 32'h05060708, 32'h15161718, 4, 1};
      vt[1] = '{1, 2, 1, 1, 4, 3, 1, 32'h0B0C0D0E, 32'h0, 32'h0B0C0D0E, 1, 0};
      vt[2] = '{0, 2, 0, 1, 3, 2, 4, 32'h01020304, 32'h05060000, 32'h0B0C0000, 4, 0};
      vt[3] = '{3, 1, 0, 2, 4, 3, 0, 32'h0, 32'h0, 32'h0, 0, 0};
      vt[4] = '{3, 3, 0, 2, 4, 3, 3, 32'h07080000, 32'h0F100000, 32'h17180000, 3, 0};

      repeat (3) @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      hreset = 0;
      cyc();

      for (int i = 0; i < 5; i++) begin
         qa_addr.delete(); qa_data.delete(); nb = 0;
         xs = vt[i].xs; xe = vt[i].xe; ys = vt[i].ys; ye = vt[i].ye;
         cont = 0; arm = 1;
         frame(vt[i].w, vt[i].h);
         chk($sformatf("v%0d_nw", i), 64'(qa_addr.size()), 64'(vt[i].nw));
         for (int j = 0; j < qa_addr.size(); j++)
            chk($sformatf("v%0d_addr%0d", i, j), 64'(qa_addr[j]), 64'(j));
         if (vt[i].nw > 0) begin
            chk($sformatf("v%0d_d0", i),
                qa_data.size() > 0 ? 64'(qa_data[0]) : 64'hx, 64'(vt[i].d0));
            chk($sformatf("v%0d_dl", i),
                qa_data.size() > 0 ? 64'(qa_data[qa_data.size()-1]) : 64'hx,
                64'(vt[i].dl));
         end
         if (vt[i].nw > 1)
            chk($sformatf("v%0d_d1", i),
                qa_data.size() > 1 ? 64'(qa_data[1]) : 64'hx, 64'(vt[i].d1));
         chk($sformatf("v%0d_wcnt", i), 64'(ifa.WORD_CNT), 64'(vt[i].nw));
         chk($sformatf("v%0d_rdy", i), 64'(ifa.FRAME_READY), 1);
         chk($sformatf("v%0d_fcnt", i), 64'(ifa.FRAME_CNT), 1);
         chk($sformatf("v%0d_ovf", i), 64'(ifa.OVERFLOW), 0);
         chk($sformatf("v%0d_b_nw", i), 64'(nb), 64'(vt[i].bnw));
         chk($sformatf("v%0d_b_wcnt", i), 64'(ifb.WORD_CNT), 64'(vt[i].bnw));
         chk($sformatf("v%0d_b_ovf", i), 64'(ifb.OVERFLOW), 64'(vt[i].bovf));
         arm = 0;
         repeat (3) cyc();
         chk($sformatf("v%0d_rdy_off", i), 64'(ifa.FRAME_READY), 0);
         chk($sformatf("v%0d_busy_off", i), 64'(ifa.BUSY), 0);
      end

      // Continuous mode, three back-to-back frames.
      qa_addr.delete(); qa_data.delete();
      xs = 0; xe = 3; ys = 0; ye = 2;
      cont = 1; arm = 1;
      cyc(); cyc();
      busy_watch = 1;
      for (int f = 0; f < 3; f++) begin
         frame(4, 3);
         chk($sformatf("cont_rdy%0d", f), 64'(ifa.FRAME_READY), 1);
         chk($sformatf("cont_fcnt%0d", f), 64'(ifa.FRAME_CNT), 64'(f + 1));
      end
      busy_watch = 0;
      chk("cont_busy_drop", 64'(busy_drop), 0);
      chk("cont_nw", 64'(qa_addr.size()), 18);
      chk("cont_addr6", qa_addr.size() > 6 ? 64'(qa_addr[6]) : 64'hx, 0);
      chk("cont_addr12", qa_addr.size() > 12 ? 64'(qa_addr[12]) : 64'hx, 0);
      chk("cont_addr17", qa_addr.size() > 17 ? 64'(qa_addr[17]) : 64'hx, 5);
      chk("cont_d12", qa_data.size() > 12 ? 64'(qa_data[12]) : 64'hx,
          64'h01020304);
      chk("cont_b_ovf", 64'(ifb.OVERFLOW), 1);
      cont = 0; arm = 0;
      repeat (3) cyc();

      // ARM dropped on the third beat of the first line.
      arm = 1;
      vsync = 1; repeat (4) cyc();
      vsync = 0; repeat (2) cyc();
      n0 = qa_addr.size();
      href = 1;
      data = 8'h01; cyc();
      data = 8'h02; cyc();
      data = 8'h03; arm = 0; cyc();
      for (int k = 4; k <= 8; k++) begin
         data = 8'(k);
         cyc();
      end
      href = 0; data = 0;
      repeat (3) cyc();
      chk("abort_no_we", 64'(qa_addr.size()), 64'(n0));
      chk("abort_busy", 64'(ifa.BUSY), 0);
      chk("abort_rdy", 64'(ifa.FRAME_READY), 0);
      chk("abort_fcnt_b", 64'(ifb.FRAME_CNT), 0);

      // HRESET in the middle of a line.
      arm = 1;
      vsync = 1; repeat (4) cyc();
      vsync = 0; repeat (2) cyc();
      n0 = qa_addr.size();
      href = 1;
      for (int k = 1; k <= 6; k++) begin
         data = 8'(k);
         cyc();
      end
      chk("rst_prewrite", 64'(qa_addr.size()), 64'(n0 + 1));
      #3;
      hreset = 1;
      arm = 0;
      repeat (2) @(negedge clk);
      chk_zero("midrst");
      @(posedge clk); #1;
      hreset = 0;
      n1 = qa_addr.size();
      data = 8'h07; cyc();
      data = 8'h08; cyc();
      href = 0; data = 0;
      repeat (3) cyc();
      chk("rst_no_we", 64'(qa_addr.size()), 64'(n1));
      chk("rst_busy", 64'(ifa.BUSY), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
